mem_port_arbiter: RTL

Shares the CPU's single memory port between the instruction-fetch path and the data load/store path. It latches single-cycle request pulses from both requesters and grants one transaction at a time. It drives the memory strobe/address/data, waits for memory RDY, then returns read data and a one-cycle ready pulse to the winning requester. It sits between the fetch unit / Controller (RREQ, CWE, HOLD handshake) and the memory.

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (fetch/data) and memory-side signals around the shared memory port.
// The slave modport is the arbiter's view; master is the environment (requesters + memory).
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          I_REQ;
  logic [AW-1:0] I_ADDR;
  logic [DW-1:0] I_RDATA;
  logic          I_RDY;
  logic          D_REQ;
  logic          D_WE;
  logic [AW-1:0] D_ADDR;
  logic [DW-1:0] D_WDATA;
  logic [DW-1:0] D_RDATA;
  logic          D_RDY;
  logic          M_REQ;
  logic          M_WE;
  logic [AW-1:0] M_ADDR;
  logic [DW-1:0] M_WDATA;
  logic [DW-1:0] M_RDATA;
  logic          M_RDY;
  logic          BUSY;

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, M_RDATA, M_RDY,
    output I_RDATA, I_RDY, D_RDATA, D_RDY, M_REQ, M_WE, M_ADDR, M_WDATA, BUSY
  );

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, M_RDATA, M_RDY,
    input  I_RDATA, I_RDY, D_RDATA, D_RDY, M_REQ, M_WE, M_ADDR, M_WDATA, BUSY
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store, one transaction at a time.
// Optional macro FAIR_ARB_EN selects round-robin arbitration instead of data-over-fetch priority.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t        state_q,    state_d;
  logic          i_pend_q,   i_pend_d;
  logic [AW-1:0] i_addr_q,   i_addr_d;
  logic          d_pend_q,   d_pend_d;
  logic          d_we_q,     d_we_d;
  logic [AW-1:0] d_addr_q,   d_addr_d;
  logic [DW-1:0] d_wdata_q,  d_wdata_d;
  logic          win_data_q, win_data_d;
  logic          m_req_q,    m_req_d;
  logic          m_we_q,     m_we_d;
  logic [AW-1:0] m_addr_q,   m_addr_d;
  logic [DW-1:0] m_wdata_q,  m_wdata_d;
  logic [DW-1:0] i_rdata_q,  i_rdata_d;
  logic [DW-1:0] d_rdata_q,  d_rdata_d;
  logic          i_rdy_q,    i_rdy_d;
  logic          d_rdy_q,    d_rdy_d;
  logic          busy_q,     busy_d;
  logic          win_data_s;
`ifdef FAIR_ARB_EN
  logic          last_data_q, last_data_d;
`endif

  // Request capture, arbitration and transaction sequencing
  always_comb begin
    state_d    = state_q;
    i_pend_d   = i_pend_q;
    i_addr_d   = i_addr_q;
    d_pend_d   = d_pend_q;
    d_we_d     = d_we_q;
    d_addr_d   = d_addr_q;
    d_wdata_d  = d_wdata_q;
    win_data_d = win_data_q;
    m_req_d    = 1'b0;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_rdy_d    = 1'b0;
    d_rdy_d    = 1'b0;
    win_data_s = 1'b0;
`ifdef FAIR_ARB_EN
    last_data_d = last_data_q;
`endif

    // PEND stays set through the transaction, so this also drops requests while in flight
    if (bus.I_REQ && !i_pend_q) begin
      i_pend_d = 1'b1;
      i_addr_d = bus.I_ADDR;
    end else begin
      i_pend_d = i_pend_q;
    end

    if ((bus.D_REQ || bus.D_WE) && !d_pend_q) begin
      d_pend_d  = 1'b1;
      d_we_d    = bus.D_WE;
      d_addr_d  = bus.D_ADDR;
      d_wdata_d = bus.D_WDATA;
    end else begin
      d_pend_d = d_pend_q;
    end

`ifdef FAIR_ARB_EN
    if (d_pend_d && i_pend_d) begin
      win_data_s = ~last_data_q;
    end else begin
      win_data_s = d_pend_d;
    end
`else
    win_data_s = d_pend_d;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_pend_d || d_pend_d) begin
          win_data_d = win_data_s;
          m_req_d    = 1'b1;
          if (win_data_s) begin
            m_addr_d  = d_addr_d;
            m_we_d    = d_we_d;
            m_wdata_d = d_wdata_d;
          end else begin
            m_addr_d  = i_addr_d;
            m_we_d    = 1'b0;
            m_wdata_d = {DW{1'b0}};
          end
`ifdef FAIR_ARB_EN
          last_data_d = win_data_s;
`endif
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.M_RDY) begin
          if (win_data_q) begin
            d_rdy_d  = 1'b1;
            d_pend_d = 1'b0;
            if (!d_we_q) begin
              d_rdata_d = bus.M_RDATA;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            i_rdy_d   = 1'b1;
            i_pend_d  = 1'b0;
            i_rdata_d = bus.M_RDATA;
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || i_pend_d || d_pend_d;
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      i_pend_q   <= 1'b0;
      i_addr_q   <= {AW{1'b0}};
      d_pend_q   <= 1'b0;
      d_we_q     <= 1'b0;
      d_addr_q   <= {AW{1'b0}};
      d_wdata_q  <= {DW{1'b0}};
      win_data_q <= 1'b0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= {AW{1'b0}};
      m_wdata_q  <= {DW{1'b0}};
      i_rdata_q  <= {DW{1'b0}};
      d_rdata_q  <= {DW{1'b0}};
      i_rdy_q    <= 1'b0;
      d_rdy_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_pend_q   <= i_pend_d;
      i_addr_q   <= i_addr_d;
      d_pend_q   <= d_pend_d;
      d_we_q     <= d_we_d;
      d_addr_q   <= d_addr_d;
      d_wdata_q  <= d_wdata_d;
      win_data_q <= win_data_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_rdy_q    <= i_rdy_d;
      d_rdy_q    <= d_rdy_d;
      busy_q     <= busy_d;
    end
  end

`ifdef FAIR_ARB_EN
  // Last granted port; fetch after reset so data wins the first collision
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_data_q <= 1'b0;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`endif

  assign bus.M_REQ   = m_req_q;
  assign bus.M_WE    = m_we_q;
  assign bus.M_ADDR  = m_addr_q;
  assign bus.M_WDATA = m_wdata_q;
  assign bus.I_RDATA = i_rdata_q;
  assign bus.I_RDY   = i_rdy_q;
  assign bus.D_RDATA = d_rdata_q;
  assign bus.D_RDY   = d_rdy_q;
  assign bus.BUSY    = busy_q;

endmodule
